// File: rtl/score_hi_tracker.sv
// Session high-score register with a sequential shift-add-3 binary-to-BCD
// converter feeding the HUD digit renderers; saturates to all 9s on overflow.
module score_hi_tracker #(
    parameter int NDIGITS = 4,
    parameter int SCORE_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [SCORE_W-1:0]     score,
    input  logic                   game_over,
    input  logic                   clear_hi,
    output logic [SCORE_W-1:0]     hi_value,
    output logic [4*NDIGITS-1:0]   hi_bcd,
    output logic                   busy,
    output logic                   new_hi,
    output logic                   overflow
);

    localparam int BW = 4 * NDIGITS;
    localparam int CW = $clog2(SCORE_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_COMMIT
    } state_t;

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] hi_q, hi_d;
    logic [SCORE_W-1:0] bin_q, bin_d;
    logic [BW-1:0]      acc_q, acc_d;
    logic [BW-1:0]      bcd_q, bcd_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               pending_q, pending_d;
    logic               sticky_q, sticky_d;
    logic               new_hi_q, new_hi_d;
    logic               ovf_q, ovf_d;
    logic               upd;
    logic [BW-1:0]      adj;

    always_comb begin
        adj = acc_q;
        for (int i = 0; i < NDIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        bin_d     = bin_q;
        acc_d     = acc_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        sticky_d  = sticky_q;
        ovf_d     = ovf_q;
        new_hi_d  = 1'b0;
        upd       = 1'b0;

        if (clear_hi) begin
            hi_d = '0;
            upd  = 1'b1;
        end else if (game_over && (score > hi_q)) begin
            hi_d     = score;
            new_hi_d = 1'b1;
            upd      = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                // An update on this edge starts the conversion right away
                if (pending_q || upd) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                bin_d     = hi_q;
                acc_d     = '0;
                sticky_d  = 1'b0;
                cnt_d     = '0;
                pending_d = 1'b0;
                state_d   = S_SHIFT;
            end
            S_SHIFT: begin
                acc_d    = {adj[BW-2:0], bin_q[SCORE_W-1]};
                bin_d    = {bin_q[SCORE_W-2:0], 1'b0};
                sticky_d = sticky_q | adj[BW-1];
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(SCORE_W - 1)) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                if (sticky_q) begin
                    bcd_d = {NDIGITS{4'h9}};
                    ovf_d = 1'b1;
                end else begin
                    bcd_d = acc_q;
                    ovf_d = 1'b0;
                end
                state_d = (pending_q || upd) ? S_LOAD : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (upd) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            hi_q      <= '0;
            bin_q     <= '0;
            acc_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            sticky_q  <= 1'b0;
            new_hi_q  <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            bin_q     <= bin_d;
            acc_q     <= acc_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            sticky_q  <= sticky_d;
            new_hi_q  <= new_hi_d;
            ovf_q     <= ovf_d;
        end
    end

    assign hi_value = hi_q;
    assign hi_bcd   = bcd_q;
    assign busy     = (state_q != S_IDLE);
    assign new_hi   = new_hi_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_score_hi_tracker.sv
// Directed bench for score_hi_tracker: timeline model of the high score and
// its delayed BCD publication, plus literal checks at key points.
module tb_score_hi_tracker;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] score = '0;
    logic        game_over = 1'b0;
    logic        clear_hi = 1'b0;
    logic [31:0] hi_value;
    logic [15:0] hi_bcd;
    logic        busy, new_hi, overflow;

    logic [19:0] score2 = '0;
    logic        game_over2 = 1'b0;
    logic [19:0] hi_value2;
    logic [23:0] hi_bcd2;
    logic        busy2, new_hi2, overflow2;

    int checks = 0;
    int errors = 0;

    score_hi_tracker u_dut (
        .clk(clk), .reset(reset), .score(score),
        .game_over(game_over), .clear_hi(clear_hi),
        .hi_value(hi_value), .hi_bcd(hi_bcd), .busy(busy),
        .new_hi(new_hi), .overflow(overflow)
    );

    score_hi_tracker #(.NDIGITS(6), .SCORE_W(20)) u_dut2 (
        .clk(clk), .reset(reset), .score(score2),
        .game_over(game_over2), .clear_hi(1'b0),
        .hi_value(hi_value2), .hi_bcd(hi_bcd2), .busy(busy2),
        .new_hi(new_hi2), .overflow(overflow2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // Model: each conversion is a window of W+2 edges starting at the edge
    // that makes it pending (or at the commit edge of the previous one).
    longint     m_hi = 0, m_snap = 0, m_start = 0, cyc = 0;
    logic       m_pend = 0, m_active = 0, m_newhi = 0, m_ovf = 0;
    logic [15:0] m_bcd = '0;

    function automatic logic [15:0] to_bcd(input longint v);
        logic [15:0] b;
        longint      t;
        b = '0;
        t = v;
        if (v >= 10000) return 16'h9999;
        for (int i = 0; i < 4; i++) begin
            b[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return b;
    endfunction

    always @(posedge clk) begin
        longint old_hi;
        logic   upd;
        if (reset) begin
            m_hi = 0; m_pend = 0; m_active = 0; m_newhi = 0;
            m_bcd = '0; m_ovf = 0; m_snap = 0;
        end else begin
            cyc++;
            upd = 0;
            m_newhi = 0;
            old_hi = m_hi;
            if (clear_hi) begin
                m_hi = 0; upd = 1;
            end else if (game_over && longint'(score) > m_hi) begin
                m_hi = longint'(score); m_newhi = 1; upd = 1;
            end
            if (m_active) begin
                if (cyc == m_start + 1) begin
                    m_snap = old_hi;
                    m_pend = 0;
                end
                if (cyc == m_start + 34) begin
                    m_bcd = to_bcd(m_snap);
                    m_ovf = (m_snap >= 10000);
                    m_active = 0;
                end
            end
            if (upd) m_pend = 1;
            if (!m_active && m_pend) begin
                m_active = 1;
                m_start = cyc;
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (!reset) begin
            chk("mdl_hi_value", 64'(hi_value), 64'(m_hi));
            chk("mdl_hi_bcd", 64'(hi_bcd), 64'(m_bcd));
            chk("mdl_busy", 64'(busy), 64'(m_active));
            chk("mdl_new_hi", 64'(new_hi), 64'(m_newhi));
            chk("mdl_overflow", 64'(overflow), 64'(m_ovf));
        end
    end

    // Presents inputs for one edge; returns #1 after that edge.
    task automatic pulse(input logic [31:0] v, input logic go,
                         input logic clr);
        @(negedge clk);
        score = v;
        game_over = go;
        clear_hi = clr;
        @(posedge clk);
        #1;
        game_over = 1'b0;
        clear_hi = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && busy; i++) begin
            @(posedge clk);
            #1;
        end
        chk("idle_timeout", 64'(busy), 64'd0);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_hi_value", 64'(hi_value), 64'd0);
        chk("rst_hi_bcd", 64'(hi_bcd), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_new_hi", 64'(new_hi), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);

        pulse(32'd1234, 1'b1, 1'b0);
        chk("r1234_new_hi", 64'(new_hi), 64'd1);
        chk("r1234_hi_value", 64'(hi_value), 64'd1234);
        n = 0;
        while (busy && n < 100) begin
            n++;
            if (n == 2) chk("r1234_pulse_len", 64'(new_hi), 64'd0);
            @(posedge clk);
            #1;
        end
        chk("r1234_busy_cycles", 64'(n), 64'd34);
        chk("r1234_bcd", 64'(hi_bcd), 64'h1234);
        chk("r1234_ovf", 64'(overflow), 64'd0);

        pulse(32'd999, 1'b1, 1'b0);
        chk("r999_new_hi", 64'(new_hi), 64'd0);
        chk("r999_hi_value", 64'(hi_value), 64'd1234);
        chk("r999_busy", 64'(busy), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("r999_bcd", 64'(hi_bcd), 64'h1234);

        pulse(32'd10000, 1'b1, 1'b0);
        chk("r10000_hi_value", 64'(hi_value), 64'd10000);
        wait_idle();
        chk("r10000_bcd", 64'(hi_bcd), 64'h9999);
        chk("r10000_ovf", 64'(overflow), 64'd1);

        pulse(32'd0, 1'b0, 1'b1);
        chk("clr_hi_value", 64'(hi_value), 64'd0);
        chk("clr_bcd_held", 64'(hi_bcd), 64'h9999);
        wait_idle();
        chk("clr_bcd", 64'(hi_bcd), 64'h0000);
        chk("clr_ovf", 64'(overflow), 64'd0);

        pulse(32'd50, 1'b1, 1'b1);
        chk("both_hi_value", 64'(hi_value), 64'd0);
        chk("both_new_hi", 64'(new_hi), 64'd0);
        chk("both_busy", 64'(busy), 64'd1);
        wait_idle();
        chk("both_bcd", 64'(hi_bcd), 64'h0000);

        pulse(32'd100, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        pulse(32'd200, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        pulse(32'd300, 1'b1, 1'b0);
        chk("coal_hi_value", 64'(hi_value), 64'd300);
        repeat (25) @(posedge clk);
        #1;
        chk("coal_first_bcd", 64'(hi_bcd), 64'h0100);
        chk("coal_still_busy", 64'(busy), 64'd1);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
        chk("coal_second_len", 64'(n), 64'd34);
        chk("coal_final_bcd", 64'(hi_bcd), 64'h0300);

        @(negedge clk);
        score2 = 20'hFFFFF;
        game_over2 = 1'b1;
        @(posedge clk);
        #1;
        game_over2 = 1'b0;
        chk("w20_new_hi", 64'(new_hi2), 64'd1);
        for (int i = 0; i < 100 && busy2; i++) begin
            @(posedge clk);
            #1;
        end
        chk("w20_idle", 64'(busy2), 64'd0);
        chk("w20_hi_value", 64'(hi_value2), 64'hFFFFF);
        chk("w20_bcd", 64'(hi_bcd2), 64'h999999);
        chk("w20_ovf", 64'(overflow2), 64'd1);

        pulse(32'd777, 1'b1, 1'b0);
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_hi_value", 64'(hi_value), 64'd0);
        chk("arst_hi_bcd", 64'(hi_bcd), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_new_hi", 64'(new_hi), 64'd0);
        chk("arst_overflow", 64'(overflow), 64'd0);
        chk("arst_bcd2", 64'(hi_bcd2), 64'd0);
        chk("arst_ovf2", 64'(overflow2), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        pulse(32'd42, 1'b1, 1'b0);
        wait_idle();
        chk("post_rst_bcd", 64'(hi_bcd), 64'h0042);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
